branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 37 +++
 rtl/branch_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: func3 branch
// encodings, the controller FSM state type and the sequential PC step.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator (purely combinational).
// Ports: func3/src1/src2 in; taken (condition true), illegal (func3 not a branch) out.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (src1 == src2);
    assign lt  = ($signed(src1) < $signed(src2));
    assign ltu = (src1 < src2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (1'b1)
            (func3 == F3_BEQ):  taken = eq;
            (func3 == F3_BNE):  taken = ~eq;
            (func3 == F3_BLT):  taken = lt;
            (func3 == F3_BGE):  taken = ~lt;
            (func3 == F3_BLTU): taken = ltu;
            (func3 == F3_BGEU): taken = ~ltu;
            default:            illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures an EX branch, resolves it one
// cycle later, redirects fetch on mispredict and flushes IF/ID.
// Ports: clk, rst_n (sync, active-low); br_valid/br_ready handshake with
// func3, src1, src2, pc, imm, br_pred_taken; res_valid/res_taken/illegal
// result pulse; redirect_valid/redirect_pc; flush.
// Optional macro BRANCH_PREDICT_EN adds a 16-entry 2-bit BHT with
// fetch_pc in / fetch_pred_taken out.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            br_pred_taken,
`ifdef BRANCH_PREDICT_EN
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken,
`endif
    output logic            res_valid,
    output logic            res_taken,
    output logic            illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] src1_q, src2_q, pc_q, imm_q;
    logic            pred_q;

    logic            accept;
    logic            cmp_taken;
    logic            cmp_illegal;
    logic            mispredict;
    logic [XLEN-1:0] target;

    assign accept = br_valid & br_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                f3_q   <= func3;
                src1_q <= src1;
                src2_q <= src2;
                pc_q   <= pc;
                imm_q  <= imm;
                pred_q <= br_pred_taken;
            end
        end
    end

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .func3   (f3_q),
        .src1    (src1_q),
        .src2    (src2_q),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // cmp_taken is already 0 for illegal encodings, so an illegal
    // branch mispredicts exactly when it was predicted taken.
    assign mispredict = cmp_taken ^ pred_q;
    assign target     = cmp_taken ? (pc_q + imm_q)
                                  : (pc_q + XLEN'(PC_INC));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        br_ready       = 1'b0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        illegal        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                res_valid = 1'b1;
                res_taken = cmp_taken;
                illegal   = cmp_illegal;
                if (mispredict) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target;
                    flush          = 1'b1;
                    cnt_d          = FLUSH_LEN;
                    state_d        = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef BRANCH_PREDICT_EN
    logic [1:0] bht_q [16];
    logic [3:0] upd_idx;
    logic       unused_fetch;

    assign upd_idx      = pc_q[5:2];
    assign unused_fetch = ^{fetch_pc[XLEN-1:6], fetch_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (state_q == ST_RESOLVE && !cmp_illegal) begin
            if (cmp_taken) begin
                if (bht_q[upd_idx] != 2'b11) begin
                    bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
                end
            end else begin
                if (bht_q[upd_idx] != 2'b00) begin
                    bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
                end
            end
        end
    end

    assign fetch_pred_taken = bht_q[fetch_pc[5:2]][1];
`endif

endmodule
